hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Parametrised load-use and branch hazard stall controller for the 5-stage MIPS pipeline; successor to the single-cycle load-use stall unit.
- Adds a configurable multi-cycle load stall, branch-in-ID operand hazards and register-0 exclusion.
- Adds a pipeline freeze input, a flush abort input and a saturating stall performance counter.
- Drives PC write enable, IF/ID write enable and the ID/EX bubble (control-zeroing) select.

Parameters:
REG_W, 5, register specifier width
OP_W, 6, opcode width
LOAD_STALL, 1, stall cycles for load-use in EX (legal 1..7)
BRANCH_IN_ID, 0, 1 = branches resolve in ID, so branch operand hazards are enabled
PERF_W, 16, stall performance counter width

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_mem_read  in  1  instruction in EX is a load
ex_reg_write  in  1  instruction in EX writes a register
ex_dest  in  REG_W  destination register of the EX instruction
id_rs  in  REG_W  rs field of the ID instruction
id_rt  in  REG_W  rt field of the ID instruction
id_op  in  OP_W  opcode of the ID instruction
freeze  in  1  global pipeline freeze (memory busy)
flush  in  1  ID instruction is being squashed
pc_write_en  out  1  PC update enable
ifid_write_en  out  1  IF/ID register write enable
stall_flush  out  1  insert bubble into ID/EX
stall_busy  out  1  FSM is in STALL (multi-cycle stall in progress)
perf_stall_cycles  out  PERF_W  count of bubble cycles, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset). While reset is high: state=IDLE, counter=0, perf=0, pc_write_en=0, ifid_write_en=0, stall_flush=1, stall_busy=0.
- rs_src: always 1 when id_rs!=0.
- rt_src: id_rt!=0 and id_op is NOT in the package list RT_NOT_SRC = {LW 100011, XORI 001110, ADDI 001000, ANDI 001100, ORI 001101, LUI 001111}.
- Match: m = (rs_src && id_rs==ex_dest) || (rt_src && id_rt==ex_dest). A register-0 destination never matches.
- is_br = id_op in {BEQ 000100, BNE 000101}.
- Hazard length N, evaluated combinationally in IDLE (first match wins):
  - ex_mem_read && m && is_br && BRANCH_IN_ID: N = LOAD_STALL+1
  - ex_mem_read && m: N = LOAD_STALL
  - ex_reg_write && m && is_br && BRANCH_IN_ID: N = 1
  - otherwise: N = 0 (no hazard)
- FSM states are IDLE and STALL. A 3-bit down-counter cnt holds the remaining stall cycles.
- IDLE, N>0, no freeze or flush: the stall is asserted in the SAME cycle (zero latency). pc_write_en=0, ifid_write_en=0, stall_flush=1. If N>1, go to STALL with cnt=N-1 next edge; otherwise stay in IDLE.
- STALL: stall outputs are asserted regardless of the EX inputs (the bubbles already in flight are not re-evaluated). cnt decrements each cycle. When cnt==1, the next edge returns to IDLE and cnt=0. stall_busy=1 throughout STALL.
- No hazard in IDLE: pc_write_en=1, ifid_write_en=1, stall_flush=0.
- freeze=1 (highest priority):
  - pc_write_en=0, ifid_write_en=0, stall_flush=0.
  - State, cnt and perf hold; no new hazard is latched.
  - When freeze drops, detection or the stall resumes exactly where it left off.
- flush=1 with freeze=0:
  - Next edge goes to IDLE with cnt=0.
  - Outputs this cycle are pc_write_en=1, ifid_write_en=1, stall_flush=0. Flush beats a hazard.
- freeze and flush both high: freeze wins and flush is ignored; the producer must hold flush until freeze drops.
- perf_stall_cycles: +1 on each edge where stall_flush=1 and reset=0. Saturates at all-ones with no wrap.
- Reset mid-stall: immediate return to the reset values; no residual stall after reset deasserts.
- LOAD_STALL=1 and BRANCH_IN_ID=0 reproduce the legacy single-cycle unit, except for the register-0 exclusion and the extended RT_NOT_SRC list.

Decomposition:
- Shared package hazard_pkg holds:
  - OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_XORI, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI
  - the RT_NOT_SRC membership function
  - state encodings ST_IDLE=1'b0, ST_STALL=1'b1
- One sub-module, hazard_reg_cmp: an REG_W-wide equality compare with a source-valid gate and zero-register exclusion, instantiated twice (rs, rt).

Test Plan:
- LOAD_STALL=1, ex_mem_read=1, ex_dest=8, id_rs=8, id_op=000000 -> stall_flush=1, pc_write_en=0 for exactly 1 cycle; perf 0->1.
- LOAD_STALL=3, same load-use -> 3 consecutive bubble cycles (stall_busy=1 on cycles 2-3), then pc_write_en=1; perf=3.
- BRANCH_IN_ID=1, ex_reg_write=1, ex_dest=5, id_op=000100, id_rt=5 -> 1 bubble. Repeat with ex_mem_read=1, LOAD_STALL=1 -> 2 bubbles.
- ex_mem_read=1, ex_dest=0, id_rs=0 -> no stall. ex_dest=9, id_rt=9, id_op=100011 (LW) -> no stall.
- LOAD_STALL=3: freeze=1 for 4 cycles during stall cycle 2 -> outputs 0/0/0, perf holds, then 2 remaining bubbles. Separately, flush=1 in stall cycle 2 -> pc_write_en=1 that cycle, IDLE next.
- Saturation and reset: PERF_W=2 with 5 bubbles -> perf=3; reset asserted mid-STALL -> stall_flush=1, perf=0 immediately; after release, IDLE with no bubble.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the hazard stall controller.
// Pure combinational helpers: zero latency, no flow control.
package hazard_pkg;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Opcodes whose rt field is a destination (or unused), never a read operand.
    function automatic logic rt_not_src(input logic [5:0] op);
        return (op == OP_LW)   || (op == OP_XORI) || (op == OP_ADDI) ||
               (op == OP_ANDI) || (op == OP_ORI)  || (op == OP_LUI);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/hazard_reg_cmp.sv
// Register specifier match with source-valid gate; register 0 never matches.
// Combinational, zero latency, no flow control.
module hazard_reg_cmp #(
    parameter int REG_W = 5
) (
    input  logic             src_vld_i,
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] dest_i,
    output logic             match_o
);

    assign match_o = src_vld_i && (dest_i != '0) && (src_i == dest_i);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand stall controller: asserts the bubble in the detecting cycle (zero latency).
// freeze holds all state with outputs low; flush aborts any stall and releases the pipeline.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int OP_W         = 6,
    parameter int LOAD_STALL   = 1,
    parameter int BRANCH_IN_ID = 0,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [OP_W-1:0]   id_op,
    input  logic              freeze,
    input  logic              flush,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              stall_flush,
    output logic              stall_busy,
    output logic [PERF_W-1:0] perf_stall_cycles
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    logic [5:0] op6;
    logic       rs_hit, rt_hit, m, is_br, br_en;
    logic [3:0] n_len;
    logic       bubble;

    assign op6   = 6'(id_op);
    assign is_br = is_branch(op6);
    assign br_en = (BRANCH_IN_ID != 0);

    hazard_reg_cmp #(.REG_W(REG_W)) u_cmp_rs (
        .src_vld_i (id_rs != '0),
        .src_i     (id_rs),
        .dest_i    (ex_dest),
        .match_o   (rs_hit)
    );

    hazard_reg_cmp #(.REG_W(REG_W)) u_cmp_rt (
        .src_vld_i ((id_rt != '0) && !rt_not_src(op6)),
        .src_i     (id_rt),
        .dest_i    (ex_dest),
        .match_o   (rt_hit)
    );

    assign m = rs_hit || rt_hit;

    always_comb begin
        n_len = 4'd0;
        if (ex_mem_read && m && is_br && br_en)
            n_len = 4'(LOAD_STALL + 1);
        else if (ex_mem_read && m)
            n_len = 4'(LOAD_STALL);
        else if (ex_reg_write && m && is_br && br_en)
            n_len = 4'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        if (freeze) begin
            bubble = 1'b0;
        end else if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else if (state_q == ST_STALL) begin
            // Bubbles already committed; EX inputs are not re-evaluated here.
            bubble = 1'b1;
            cnt_d  = cnt_q - 3'd1;
            if (cnt_q == 3'd1)
                state_d = ST_IDLE;
        end else if (n_len != 4'd0) begin
            bubble = 1'b1;
            if (n_len > 4'd1) begin
                state_d = ST_STALL;
                cnt_d   = 3'(n_len - 4'd1);
            end
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (bubble && (perf_q != {PERF_W{1'b1}}))
            perf_d = perf_q + PERF_W'(1);
    end

    always_comb begin
        pc_write_en   = !freeze && !bubble;
        ifid_write_en = !freeze && !bubble;
        stall_flush   = bubble;
        if (reset) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            stall_flush   = 1'b1;
        end
    end

    assign stall_busy        = (state_q == ST_STALL) && !reset;
    assign perf_stall_cycles = perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Three parameter variants driven in lockstep; a bubble-count reference model feeds a scoreboard.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ex_mem_read, ex_reg_write, freeze, flush;
    logic [4:0] ex_dest, id_rs, id_rt;
    logic [5:0] id_op;

    logic [2:0]  pc_w, ifid_w, sf_w, busy_w;
    logic [15:0] perf_a, perf_b;
    logic [1:0]  perf_c;

    hazard_stall_ctrl #(.LOAD_STALL(3), .BRANCH_IN_ID(1), .PERF_W(16)) u_a (
        .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op),
        .freeze(freeze), .flush(flush), .pc_write_en(pc_w[0]), .ifid_write_en(ifid_w[0]),
        .stall_flush(sf_w[0]), .stall_busy(busy_w[0]), .perf_stall_cycles(perf_a));

    hazard_stall_ctrl #(.LOAD_STALL(1), .BRANCH_IN_ID(1), .PERF_W(16)) u_b (
        .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op),
        .freeze(freeze), .flush(flush), .pc_write_en(pc_w[1]), .ifid_write_en(ifid_w[1]),
        .stall_flush(sf_w[1]), .stall_busy(busy_w[1]), .perf_stall_cycles(perf_b));

    hazard_stall_ctrl #(.LOAD_STALL(1), .BRANCH_IN_ID(0), .PERF_W(2)) u_c (
        .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op),
        .freeze(freeze), .flush(flush), .pc_write_en(pc_w[2]), .ifid_write_en(ifid_w[2]),
        .stall_flush(sf_w[2]), .stall_busy(busy_w[2]), .perf_stall_cycles(perf_c));

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        sf;
        logic        busy;
        logic [15:0] perf;
    } exp_t;

    typedef struct packed {
        exp_t [2:0] e;
    } row_t;

    row_t sb_q[$];
    row_t mon_exp, mon_got;

    int total = 0;
    int bad   = 0;
    int mcyc  = 0;

    int m_ls[3]   = '{3, 1, 1};
    int m_br[3]   = '{1, 1, 0};
    int m_pw[3]   = '{16, 16, 2};
    int m_rem[3]  = '{0, 0, 0};
    int m_perf[3] = '{0, 0, 0};

    logic [5:0] ops[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b000101, 6'b001000, 6'b001111, 6'b001101};

    // Number of bubbles owed for the current ID/EX pair, straight from the hazard rules.
    function automatic int hz_len(input int ls, input int br, input logic mr, input logic rw,
                                  input logic [4:0] d, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [5:0] op);
        bit rt_src, m, is_br;
        rt_src = (rt != 0) && !(op inside {6'b100011, 6'b001110, 6'b001000,
                                           6'b001100, 6'b001101, 6'b001111});
        m      = (d != 0) && (((rs != 0) && (rs == d)) || (rt_src && (rt == d)));
        is_br  = op inside {6'b000100, 6'b000101};
        if (mr && m && is_br && br != 0) return ls + 1;
        if (mr && m)                     return ls;
        if (rw && m && is_br && br != 0) return 1;
        return 0;
    endfunction

    task automatic step(input logic mr, input logic rw, input logic [4:0] d,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] op,
                        input logic frz, input logic fl, input logic rst);
        row_t r;
        exp_t x;
        int   n;
        @(posedge clk);
        #2;
        ex_mem_read = mr; ex_reg_write = rw; ex_dest = d;
        id_rs = rs; id_rt = rt; id_op = op;
        freeze = frz; flush = fl; reset = rst;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                x = '{pc: 1'b0, ifid: 1'b0, sf: 1'b1, busy: 1'b0, perf: 16'd0};
                m_rem[i]  = 0;
                m_perf[i] = 0;
            end else begin
                x.busy = (m_rem[i] > 0);
                x.perf = 16'(m_perf[i]);
                x.pc = 1'b1; x.ifid = 1'b1; x.sf = 1'b0;
                n = 0;
                if (frz) begin
                    x.pc = 1'b0; x.ifid = 1'b0;
                end else if (fl) begin
                    m_rem[i] = 0;
                end else if (m_rem[i] > 0) begin
                    n = 1;
                    m_rem[i] = m_rem[i] - 1;
                end else begin
                    n = hz_len(m_ls[i], m_br[i], mr, rw, d, rs, rt, op);
                    if (n > 0) m_rem[i] = n - 1;
                end
                if (!frz && !fl && n > 0) begin
                    x.pc = 1'b0; x.ifid = 1'b0; x.sf = 1'b1;
                    if (m_perf[i] < (1 << m_pw[i]) - 1) m_perf[i] = m_perf[i] + 1;
                end
            end
            r.e[i] = x;
        end
        sb_q.push_back(r);
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_use();
        step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mcyc++;
                mon_exp = sb_q.pop_front();
                mon_got.e[0] = '{pc_w[0], ifid_w[0], sf_w[0], busy_w[0], perf_a};
                mon_got.e[1] = '{pc_w[1], ifid_w[1], sf_w[1], busy_w[1], perf_b};
                mon_got.e[2] = '{pc_w[2], ifid_w[2], sf_w[2], busy_w[2], {14'd0, perf_c}};
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (mon_got.e[i] !== mon_exp.e[i]) begin
                        bad++;
                        $display("FAIL outputs cyc=%0d inst=%0d got pc=%b ifid=%b sf=%b busy=%b perf=%0d want pc=%b ifid=%b sf=%b busy=%b perf=%0d",
                                 mcyc, i, mon_got.e[i].pc, mon_got.e[i].ifid, mon_got.e[i].sf,
                                 mon_got.e[i].busy, mon_got.e[i].perf, mon_exp.e[i].pc,
                                 mon_exp.e[i].ifid, mon_exp.e[i].sf, mon_exp.e[i].busy,
                                 mon_exp.e[i].perf);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dest = '0;
        id_rs = '0; id_rt = '0; id_op = '0; freeze = 1'b0; flush = 1'b0;

        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        load_use();
        idle(4);
        step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 6'b000100, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 6'b000100, 1'b0, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 6'b100011, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Freeze for four cycles during the second stall cycle.
        load_use();
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 6'd0, 1'b1, 1'b0, 1'b0);
        idle(5);
        // Flush in the second stall cycle, then freeze+flush together.
        load_use();
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 6'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        load_use();
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 6'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 6'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        // Reset in the middle of a multi-cycle stall.
        load_use();
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 6'd0, 1'b0, 1'b0, 1'b1);
        idle(4);

        for (int k = 0; k < 1500; k++) begin
            step(($urandom % 3) == 0, ($urandom % 2) == 0,
                 (($urandom % 8) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
                 (($urandom % 8) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
                 (($urandom % 8) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
                 ops[$urandom % 8],
                 ($urandom % 10) == 0, ($urandom % 12) == 0, ($urandom % 97) == 0);
        end
        idle(2);

        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
